mac_feeder: RTL

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/mac_feeder_buf.sv | 42 ++++
 rtl/mac_feeder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder.
package systolic_pkg;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4
  } feeder_state_e;

  // Number of cycles needed to push a klen-deep job through an MxN skew.
  function automatic int unsigned skew_len(input int unsigned klen,
                                           input int unsigned m_rows,
                                           input int unsigned n_cols);
    return klen + m_rows + n_cols - 2;
  endfunction

endpackage

// File: rtl/mac_feeder_buf.sv
// K-slice operand store: one slice written per accepted beat, and every
// A/B lane reads its own slice index so the skew can be applied per lane.
module mac_feeder_buf
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int M_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int K_DEPTH    = 8,
  parameter int AW         = 3
) (
  input  logic                                 clk_i,
  input  logic                                 wr_en_i,
  input  logic [AW-1:0]                        wr_idx_i,
  input  logic [M_ROWS-1:0][DATA_WIDTH-1:0]    wr_a_i,
  input  logic [N_COLS-1:0][DATA_WIDTH-1:0]    wr_b_i,
  input  logic [M_ROWS-1:0][AW-1:0]            rd_idx_a_i,
  input  logic [N_COLS-1:0][AW-1:0]            rd_idx_b_i,
  output logic [M_ROWS-1:0][DATA_WIDTH-1:0]    rd_a_o,
  output logic [N_COLS-1:0][DATA_WIDTH-1:0]    rd_b_o
);

  logic [M_ROWS-1:0][DATA_WIDTH-1:0] mem_a [K_DEPTH];
  logic [N_COLS-1:0][DATA_WIDTH-1:0] mem_b [K_DEPTH];

  // Slice write; contents are never reset since every job rewrites what it reads.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_a[wr_idx_i] <= wr_a_i;
      mem_b[wr_idx_i] <= wr_b_i;
    end
  end

  // Per-lane read taps; the top registers these into the output lanes.
  for (genvar gi = 0; gi < M_ROWS; gi++) begin : g_rd_a
    assign rd_a_o[gi] = mem_a[rd_idx_a_i[gi]][gi];
  end
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_rd_b
    assign rd_b_o[gi] = mem_b[rd_idx_b_i[gi]][gi];
  end

endmodule

// File: rtl/mac_feeder.sv
// Buffers a K-deep job of A/B slices, then streams them diagonally skewed
// into an MxN MAC array, framed by a clear cycle and a zero drain.
module mac_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int M_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int K_DEPTH      = 8,
  parameter int DRAIN_CYCLES = 2,
  localparam int KW = $clog2(K_DEPTH + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [KW-1:0]                     k_len_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [M_ROWS-1:0][DATA_WIDTH-1:0] in_a_i,
  input  logic [N_COLS-1:0][DATA_WIDTH-1:0] in_b_i,
  output logic [M_ROWS-1:0][DATA_WIDTH-1:0] array_a_o,
  output logic [N_COLS-1:0][DATA_WIDTH-1:0] array_b_o,
  output logic                              feed_a_valid_o,
  output logic                              feed_b_valid_o,
  output logic                              a_clr_o,
  output logic                              b_clr_o,
  output logic                              acc_clr_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int AW   = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int CMAX = (K_DEPTH + M_ROWS + N_COLS > DRAIN_CYCLES) ?
                        (K_DEPTH + M_ROWS + N_COLS) : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  feeder_state_e state_q;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q, busy_q, done_q, clr_q, valid_q;

  logic [CW-1:0] feed_len;
  logic [CW-1:0] t_next;
  logic          feed_next;
  logic          wr_en;
  logic [M_ROWS-1:0]                 en_a;
  logic [N_COLS-1:0]                 en_b;
  logic [M_ROWS-1:0][AW-1:0]         idx_a;
  logic [N_COLS-1:0][AW-1:0]         idx_b;
  logic [M_ROWS-1:0][DATA_WIDTH-1:0] rd_a, lane_a_q;
  logic [N_COLS-1:0][DATA_WIDTH-1:0] rd_b, lane_b_q;

  assign feed_len = CW'(skew_len(32'(klen_q), M_ROWS, N_COLS));
  assign wr_en    = (state_q == ST_LOAD) && ready_q && in_valid_i;

  // Slice time the lanes will show after the next edge, so lane data lands with the state.
  always_comb begin
    feed_next = 1'b0;
    t_next    = '0;
    if (state_q == ST_CLEAR) begin
      feed_next = 1'b1;
    end else if ((state_q == ST_FEED) && (cnt_q != feed_len - CW'(1))) begin
      feed_next = 1'b1;
      t_next    = cnt_q + CW'(1);
    end
  end

  for (genvar gi = 0; gi < M_ROWS; gi++) begin : g_idx_a
    // Row gi lags the array edge by gi cycles: it carries slice t-gi when in range.
    always_comb begin
      en_a[gi]  = (t_next >= CW'(gi)) && ((t_next - CW'(gi)) < CW'(klen_q));
      idx_a[gi] = en_a[gi] ? AW'(t_next - CW'(gi)) : '0;
    end
  end
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_idx_b
    // Column gi lags by gi cycles in the same way.
    always_comb begin
      en_b[gi]  = (t_next >= CW'(gi)) && ((t_next - CW'(gi)) < CW'(klen_q));
      idx_b[gi] = en_b[gi] ? AW'(t_next - CW'(gi)) : '0;
    end
  end

  mac_feeder_buf #(
    .DATA_WIDTH(DATA_WIDTH), .M_ROWS(M_ROWS), .N_COLS(N_COLS),
    .K_DEPTH(K_DEPTH), .AW(AW)
  ) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_idx_i  (k_q[AW-1:0]),
    .wr_a_i    (in_a_i),
    .wr_b_i    (in_b_i),
    .rd_idx_a_i(idx_a),
    .rd_idx_b_i(idx_b),
    .rd_a_o    (rd_a),
    .rd_b_o    (rd_b)
  );

  for (genvar gi = 0; gi < M_ROWS; gi++) begin : g_lane_a
    // Registered A lane: operand when in its skew window, zero otherwise.
    always_ff @(posedge clk_i) begin
      if (rst_i) lane_a_q[gi] <= '0;
      else       lane_a_q[gi] <= (feed_next && en_a[gi]) ? rd_a[gi] : '0;
    end
  end
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_lane_b
    // Registered B lane: operand when in its skew window, zero otherwise.
    always_ff @(posedge clk_i) begin
      if (rst_i) lane_b_q[gi] <= '0;
      else       lane_b_q[gi] <= (feed_next && en_b[gi]) ? rd_b[gi] : '0;
    end
  end

  // Job sequencer with registered control outputs. in_ready rises one cycle
  // after entering LOAD, giving a single setup cycle before beats are taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (k_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              klen_q  <= (k_len_i > KW'(K_DEPTH)) ? KW'(K_DEPTH) : k_len_i;
              k_q     <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (in_valid_i) begin
            if (k_q == klen_q - KW'(1)) begin
              state_q <= ST_CLEAR;
              ready_q <= 1'b0;
              clr_q   <= 1'b1;
              k_q     <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        ST_CLEAR: begin
          state_q <= ST_FEED;
          clr_q   <= 1'b0;
          valid_q <= 1'b1;
          cnt_q   <= '0;
        end
        ST_FEED: begin
          if (cnt_q == feed_len - CW'(1)) begin
            cnt_q <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o     = ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign a_clr_o        = clr_q;
  assign b_clr_o        = clr_q;
  assign acc_clr_o      = clr_q;
  assign feed_a_valid_o = valid_q;
  assign feed_b_valid_o = valid_q;
  assign array_a_o      = lane_a_q;
  assign array_b_o      = lane_b_q;

endmodule
